text_console_writer: RTL
========================

TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 SHALL have port clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-002 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port char_valid, input, 1: a character is offered.
REQ-004 SHALL have port char_ready, output, 1: the character is accepted when char_valid && char_ready.
REQ-005 SHALL have port char_data, input, 8: character code.
REQ-006 SHALL have port char_attr, input, 8: attribute byte, written to the VRAM word bits [15:8].
REQ-007 SHALL have port clear_req, input, 1: single-cycle request to clear the screen and relatch the mode.
REQ-008 SHALL have port mode16, input, 1: 0 selects 8x8 font (W=80, H=60); 1 selects 16x16 font (W=40, H=30).
REQ-009 SHALL have port vram_we, output, 1: VRAM write strobe.
REQ-010 SHALL have port vram_waddr, output, 13: VRAM write address.
REQ-011 SHALL have port vram_wdata, output, 16: VRAM write data, {attr, char}.
REQ-012 SHALL have port vram_raddr, output, 13: VRAM read address; read data returns 1 cycle later.
REQ-013 SHALL have port vram_rdata, input, 16: VRAM read data.
REQ-014 SHALL have port cursor, output, 13: cursor position {row[5:0], col[6:0]}, in the display cursor format.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-016 SHALL compute the VRAM address as row*W+col: (row<<6)+(row<<4)+col when W=80; (row<<5)+(row<<3)+col when W=40.
REQ-017 SHALL implement states IDLE, CLEAR, SCROLL and CLRLINE.
REQ-018 SHALL drive char_ready = (state==IDLE) && !clear_req, combinationally.
REQ-019 SHALL, for an accepted printable character (0x20..0x7E), assert vram_we for one cycle on the next edge, with vram_waddr = address(cursor) and vram_wdata = {char_attr, char_data}.
REQ-020 SHALL, in that same edge, advance col by 1.
REQ-021 SHALL, when col reaches W, set col = 0 and increment row.
REQ-022 SHALL accept one character per cycle back-to-back while in IDLE.
REQ-023 SHALL handle 0x0D (CR) as col = 0, with no write.
REQ-024 SHALL handle 0x0A (LF) as col = 0, row + 1, with no write.
REQ-025 SHALL handle 0x08 (BS) as follows: if col > 0, col - 1 and write {char_attr, 0x20} at the new position; if col = 0, no action.
REQ-026 SHALL ignore all other character codes; they are accepted with no effect.
REQ-027 SHALL, when a row increment would make row = H, keep row = H-1, set col = 0, and enter SCROLL instead.
REQ-028 SHALL, in SCROLL, for k = 0..(H-1)*W-1, drive vram_raddr = W+k in cycle k, and write vram_rdata to address k in cycle k+1.
REQ-029 SHALL then enter CLRLINE, writing 0x0000 to addresses (H-1)*W .. H*W-1, one per cycle, and then return to IDLE.
REQ-030 SHALL, on clear_req in IDLE, latch mode16, enter CLEAR, write 0x0000 to addresses 0..H*W-1 one per cycle (H, W from the new mode), set cursor = 0, and return to IDLE.
REQ-031 SHALL give clear_req priority when clear_req and char_valid occur in the same cycle; the character is not accepted.
REQ-032 SHALL ignore clear_req outside IDLE.
REQ-033 SHALL hold vram_we low in IDLE whenever no character is accepted.

Reset
REQ-034 SHALL, on rstn low, immediately force state=IDLE, vram_we=0, vram_waddr=0, vram_wdata=0, vram_raddr=0, cursor=0, busy=0 and latched mode=0 (8x8).
REQ-035 SHALL abort any SCROLL or CLEAR in progress on reset, with no further writes.
REQ-036 SHALL drive char_ready=1 from the first clock edge after rstn is released.

Structure
REQ-037 SHALL place in shared package vga_text_pkg: the W/H constants per mode, the control codes (0x08, 0x0A, 0x0D, 0x20), the 13-bit address and cursor widths, and the state enum.
REQ-038 SHALL use one combinational sub-module, text_addr_gen (row, col, mode -> 13-bit address), for both the cursor write address and the scroll indices.

Verification
REQ-039 SHALL verify: after reset, send 'A' (0x41) with attr 0x07 -> next cycle vram_we=1, waddr=0, wdata=0x0741, cursor=0x0001.
REQ-040 SHALL verify: in 8x8 mode, 81 back-to-back 'x' characters -> last write at addr 80, cursor={row 1, col 1}, with no stall.
REQ-041 SHALL verify: cursor at {59, 79}, send 'Z' -> write at addr 4799, then busy for 4721 SCROLL cycles and 80 CLRLINE cycles, then cursor={59, 0}; VRAM row 0 holds the former row 1 content.
REQ-042 SHALL verify: clear_req with mode16=1 -> 1200 writes of 0x0000 to addresses 0..1199, cursor=0; a subsequent 'B' at {1, 0} writes address 40.
REQ-043 SHALL verify: BS at col 0 -> no write; CR at col 5 -> col 0 with no write; same-cycle clear_req and char_valid -> char_ready=0 and CLEAR is entered.
REQ-044 SHALL verify: rstn asserted mid-SCROLL -> vram_we=0 immediately, cursor=0, and no further writes after release.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared definitions for the text console writer: screen geometry per font
// mode, control codes, address/cursor widths and the writer state encoding.
package vga_text_pkg;

  localparam int ADDR_W   = 13;
  localparam int CURSOR_W = 13;
  localparam int ROW_W    = 6;
  localparam int COL_W    = 7;

  // Screen geometry: 8x8 font gives 80x60 cells, 16x16 font gives 40x30.
  localparam logic [COL_W-1:0]  W_8X8   = 7'd80;
  localparam logic [COL_W-1:0]  W_16X16 = 7'd40;
  localparam logic [ROW_W-1:0]  H_8X8   = 6'd60;
  localparam logic [ROW_W-1:0]  H_16X16 = 6'd30;

  // Number of cells moved up by one scroll: (H-1)*W.
  localparam logic [ADDR_W-1:0] SCROLL_LEN_8X8   = 13'd4720;
  localparam logic [ADDR_W-1:0] SCROLL_LEN_16X16 = 13'd1160;

  localparam logic [7:0] CH_BS         = 8'h08;
  localparam logic [7:0] CH_LF         = 8'h0A;
  localparam logic [7:0] CH_CR         = 8'h0D;
  localparam logic [7:0] CH_SP         = 8'h20;
  localparam logic [7:0] CH_LAST_PRINT = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_SCROLL  = 2'd2,
    ST_CLRLINE = 2'd3
  } state_e;

  function automatic logic [COL_W-1:0] cols_of(input logic mode);
    return mode ? W_16X16 : W_8X8;
  endfunction

  function automatic logic [ROW_W-1:0] rows_of(input logic mode);
    return mode ? H_16X16 : H_8X8;
  endfunction

  function automatic logic [ADDR_W-1:0] scroll_len_of(input logic mode);
    return mode ? SCROLL_LEN_16X16 : SCROLL_LEN_8X8;
  endfunction

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CH_SP) && (c <= CH_LAST_PRINT);
  endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Character input, clear control and VRAM port bundle of the console writer.
// master = character source / VRAM owner, slave = the writer itself.
interface text_console_writer_if;
  import vga_text_pkg::*;

  logic                char_valid;
  logic                char_ready;
  logic [7:0]          char_data;
  logic [7:0]          char_attr;
  logic                clear_req;
  logic                mode16;
  logic                vram_we;
  logic [ADDR_W-1:0]   vram_waddr;
  logic [15:0]         vram_wdata;
  logic [ADDR_W-1:0]   vram_raddr;
  logic [15:0]         vram_rdata;
  logic [CURSOR_W-1:0] cursor;
  logic                busy;

  modport master (
    output char_valid, char_data, char_attr, clear_req, mode16, vram_rdata,
    input  char_ready, vram_we, vram_waddr, vram_wdata, vram_raddr, cursor, busy
  );

  modport slave (
    input  char_valid, char_data, char_attr, clear_req, mode16, vram_rdata,
    output char_ready, vram_we, vram_waddr, vram_wdata, vram_raddr, cursor, busy
  );

endinterface

// File: rtl/text_addr_gen.sv
// Cell address generator: row*W+col using shift-add (W=80 or W=40).
module text_addr_gen
  import vga_text_pkg::*;
(
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  input  logic              mode,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] row_x_s;
  logic [ADDR_W-1:0] col_x_s;

  // row*80 = (row<<6)+(row<<4); row*40 = (row<<5)+(row<<3)
  always_comb begin
    row_x_s = {7'd0, row};
    col_x_s = {6'd0, col};
    if (mode) begin
      addr = (row_x_s << 5) + (row_x_s << 3) + col_x_s;
    end else begin
      addr = (row_x_s << 6) + (row_x_s << 4) + col_x_s;
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// Text console writer: places characters into a VRAM cell array at the cursor,
// handles CR/LF/BS, scrolls the screen up one line at the bottom and clears
// the screen on request (relatching the font mode).
module text_console_writer
  import vga_text_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  text_console_writer_if.slave bus
);

  state_e            state_r, state_nx_s;
  logic              mode_r, mode_nx_s;
  logic [ROW_W-1:0]  row_r, row_nx_s;
  logic [COL_W-1:0]  col_r, col_nx_s;
  logic [ROW_W-1:0]  scan_row_r, scan_row_nx_s;
  logic [COL_W-1:0]  scan_col_r, scan_col_nx_s;
  logic [ADDR_W-1:0] cnt_r, cnt_nx_s;
  logic              pend_r, pend_nx_s;
  logic              we_r, we_nx_s;
  logic [ADDR_W-1:0] waddr_r, waddr_nx_s;
  logic [15:0]       wdata_r, wdata_nx_s;
  logic [ADDR_W-1:0] raddr_r, raddr_nx_s;
  logic              busy_r;

  logic [COL_W-1:0]  w_s;
  logic [ROW_W-1:0]  h_s;
  logic [ADDR_W-1:0] scroll_len_s;
  logic [ROW_W-1:0]  gen_row_s;
  logic [COL_W-1:0]  gen_col_s;
  logic [ADDR_W-1:0] gen_addr_s;
  logic              row_inc_s;

  assign w_s          = cols_of(mode_r);
  assign h_s          = rows_of(mode_r);
  assign scroll_len_s = scroll_len_of(mode_r);

  // In IDLE the generator addresses the cursor cell (one left of it for a
  // backspace); in the bulk states it follows the scan pointer.
  always_comb begin
    gen_row_s = scan_row_r;
    gen_col_s = scan_col_r;
    if (state_r == ST_IDLE) begin
      gen_row_s = row_r;
      if ((bus.char_data == CH_BS) && (col_r != 7'd0)) begin
        gen_col_s = col_r - 7'd1;
      end else begin
        gen_col_s = col_r;
      end
    end else begin
      gen_row_s = scan_row_r;
      gen_col_s = scan_col_r;
    end
  end

  text_addr_gen u_addr_gen (
    .row  (gen_row_s),
    .col  (gen_col_s),
    .mode (mode_r),
    .addr (gen_addr_s)
  );

  // Next-state and next-output decode for the writer FSM.
  always_comb begin
    state_nx_s    = state_r;
    mode_nx_s     = mode_r;
    row_nx_s      = row_r;
    col_nx_s      = col_r;
    scan_row_nx_s = scan_row_r;
    scan_col_nx_s = scan_col_r;
    cnt_nx_s      = cnt_r;
    pend_nx_s     = 1'b0;
    we_nx_s       = 1'b0;
    waddr_nx_s    = waddr_r;
    wdata_nx_s    = wdata_r;
    raddr_nx_s    = raddr_r;
    row_inc_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.clear_req) begin
          mode_nx_s     = bus.mode16;
          state_nx_s    = ST_CLEAR;
          row_nx_s      = 6'd0;
          col_nx_s      = 7'd0;
          scan_row_nx_s = 6'd0;
          scan_col_nx_s = 7'd0;
        end else if (bus.char_valid) begin
          if (is_printable(bus.char_data)) begin
            we_nx_s    = 1'b1;
            waddr_nx_s = gen_addr_s;
            wdata_nx_s = {bus.char_attr, bus.char_data};
            if (col_r == (w_s - 7'd1)) begin
              col_nx_s  = 7'd0;
              row_inc_s = 1'b1;
            end else begin
              col_nx_s = col_r + 7'd1;
            end
          end else if (bus.char_data == CH_CR) begin
            col_nx_s = 7'd0;
          end else if (bus.char_data == CH_LF) begin
            col_nx_s  = 7'd0;
            row_inc_s = 1'b1;
          end else if ((bus.char_data == CH_BS) && (col_r != 7'd0)) begin
            col_nx_s   = col_r - 7'd1;
            we_nx_s    = 1'b1;
            waddr_nx_s = gen_addr_s;
            wdata_nx_s = {bus.char_attr, CH_SP};
          end else begin
            // BS at column 0 and unknown codes are consumed silently.
            col_nx_s = col_r;
          end

          if (row_inc_s) begin
            if (row_r == (h_s - 6'd1)) begin
              // Bottom line: cursor stays on the last row, screen moves up.
              col_nx_s      = 7'd0;
              state_nx_s    = ST_SCROLL;
              cnt_nx_s      = 13'd0;
              raddr_nx_s    = {6'd0, w_s};
              scan_row_nx_s = 6'd1;
              scan_col_nx_s = 7'd1;
            end else begin
              row_nx_s = row_r + 6'd1;
            end
          end else begin
            row_nx_s = row_r;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      ST_SCROLL: begin
        // cnt_r is the scroll cycle k: read of W+k is on raddr, and the
        // data read in the previous cycle is written back one row higher.
        pend_nx_s = (cnt_r < scroll_len_s);
        if (pend_r) begin
          we_nx_s    = 1'b1;
          waddr_nx_s = cnt_r - 13'd1;
          wdata_nx_s = bus.vram_rdata;
        end else begin
          we_nx_s = 1'b0;
        end
        if ((cnt_r + 13'd1) < scroll_len_s) begin
          raddr_nx_s = gen_addr_s;
          if (scan_col_r == (w_s - 7'd1)) begin
            scan_col_nx_s = 7'd0;
            scan_row_nx_s = scan_row_r + 6'd1;
          end else begin
            scan_col_nx_s = scan_col_r + 7'd1;
          end
        end else begin
          raddr_nx_s = raddr_r;
        end
        if (cnt_r == scroll_len_s) begin
          state_nx_s    = ST_CLRLINE;
          cnt_nx_s      = 13'd0;
          scan_row_nx_s = h_s - 6'd1;
          scan_col_nx_s = 7'd0;
        end else begin
          cnt_nx_s = cnt_r + 13'd1;
        end
      end

      ST_CLRLINE: begin
        we_nx_s    = 1'b1;
        waddr_nx_s = gen_addr_s;
        wdata_nx_s = 16'h0000;
        if (scan_col_r == (w_s - 7'd1)) begin
          state_nx_s = ST_IDLE;
        end else begin
          scan_col_nx_s = scan_col_r + 7'd1;
        end
      end

      ST_CLEAR: begin
        we_nx_s    = 1'b1;
        waddr_nx_s = gen_addr_s;
        wdata_nx_s = 16'h0000;
        if (scan_col_r == (w_s - 7'd1)) begin
          scan_col_nx_s = 7'd0;
          if (scan_row_r == (h_s - 6'd1)) begin
            state_nx_s = ST_IDLE;
          end else begin
            scan_row_nx_s = scan_row_r + 6'd1;
          end
        end else begin
          scan_col_nx_s = scan_col_r + 7'd1;
        end
      end

      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, cursor, scan and VRAM port registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      mode_r     <= 1'b0;
      row_r      <= 6'd0;
      col_r      <= 7'd0;
      scan_row_r <= 6'd0;
      scan_col_r <= 7'd0;
      cnt_r      <= 13'd0;
      pend_r     <= 1'b0;
      we_r       <= 1'b0;
      waddr_r    <= 13'd0;
      wdata_r    <= 16'h0000;
      raddr_r    <= 13'd0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      mode_r     <= mode_nx_s;
      row_r      <= row_nx_s;
      col_r      <= col_nx_s;
      scan_row_r <= scan_row_nx_s;
      scan_col_r <= scan_col_nx_s;
      cnt_r      <= cnt_nx_s;
      pend_r     <= pend_nx_s;
      we_r       <= we_nx_s;
      waddr_r    <= waddr_nx_s;
      wdata_r    <= wdata_nx_s;
      raddr_r    <= raddr_nx_s;
      busy_r     <= (state_nx_s != ST_IDLE);
    end
  end

  assign bus.char_ready = (state_r == ST_IDLE) && !bus.clear_req;
  assign bus.vram_we    = we_r;
  assign bus.vram_waddr = waddr_r;
  assign bus.vram_wdata = wdata_r;
  assign bus.vram_raddr = raddr_r;
  assign bus.cursor     = {row_r, col_r};
  assign bus.busy       = busy_r;

endmodule
